// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the controller FSM encoding and the register-zero constant.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } ctrl_state_e;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         DEF_TIMEOUT = 64;
   localparam int         DEF_CNT_W   = 16;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the EX-stage load and the ID-stage sources.
// Kept standalone so forwarding-related checks can reuse the same comparison.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       hit
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_rt == id_rs);
      rt_match = id_uses_rt && (ex_rt == id_rt);
      // Writes to $zero never create a real dependency.
      hit      = mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: halt > memory freeze >
// taken branch > load-use, plus a memory-wait FSM with fatal timeout and saturating perf counters.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IDEXMemRead,
   input  logic [4:0]       IDEXRegisterRt,
   input  logic [4:0]       IFIDRegisterRs,
   input  logic [4:0]       IFIDRegisterRt,
   input  logic             IFIDUsesRt,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PCwrite,
   output logic             IFIDwrite,
   output logic             pipe_adv,
   output logic             controlmux,
   output logic             IFIDflush,
   output logic             IDEXflush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   ctrl_state_e       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;

   logic lu;
   logic mf;
   logic stall_inc;
   logic flush_inc;

   load_use_detect u_lud (
      .mem_read   (IDEXMemRead),
      .ex_rt      (IDEXRegisterRt),
      .id_rs      (IFIDRegisterRs),
      .id_rt      (IFIDRegisterRt),
      .id_uses_rt (IFIDUsesRt),
      .hit        (lu)
   );

   // Enable/flush priority mux; reset holds the pipe like HALT does.
   always_comb begin
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      pipe_adv   = 1'b0;
      controlmux = 1'b1;
      IFIDflush  = 1'b0;
      IDEXflush  = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      mf = ((state_q == MEM_WAIT) || ((state_q == RUN) && dmem_req)) && !dmem_ready;

      if (!rst_n || (state_q == HALT)) begin
         controlmux = 1'b1;
      end else if (mf) begin
         controlmux = 1'b0;
         stall_inc  = 1'b1;
      end else if (branch_taken) begin
         PCwrite    = 1'b1;
         IFIDwrite  = 1'b1;
         pipe_adv   = 1'b1;
         controlmux = 1'b0;
         IFIDflush  = 1'b1;
         IDEXflush  = 1'b1;
         flush_inc  = 1'b1;
      end else if (lu) begin
         pipe_adv   = 1'b1;
         controlmux = 1'b1;
         stall_inc  = 1'b1;
      end else begin
         PCwrite    = 1'b1;
         IFIDwrite  = 1'b1;
         pipe_adv   = 1'b1;
         controlmux = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         RUN: begin
            wait_d = '0;
            if (dmem_req && !dmem_ready) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            wait_d = wait_q + WAIT_W'(1);
            if (dmem_ready)              state_d = RUN;
            else if (wait_q == WAIT_LAST) state_d = HALT;
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase

      stall_d = stall_q;
      if (stall_inc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
      flush_d = flush_q;
      if (flush_inc && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wait_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign mem_timeout  = (state_q == HALT);
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (TIMEOUT=4, CNT_W=4): hazards, branch flush,
// memory freeze, timeout halt with async reset recovery, and counter saturation.
module tb_pipe_stall_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int TO = 4;
   localparam int CW = 4;

   // {PCwrite, IFIDwrite, pipe_adv, controlmux, IFIDflush, IDEXflush}
   localparam logic [5:0] C_NORM = 6'b111000;
   localparam logic [5:0] C_LU   = 6'b001100;
   localparam logic [5:0] C_BR   = 6'b111011;
   localparam logic [5:0] C_FRZ  = 6'b000000;
   localparam logic [5:0] C_HOLD = 6'b000100;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          IDEXMemRead;
   logic [4:0]    IDEXRegisterRt;
   logic [4:0]    IFIDRegisterRs;
   logic [4:0]    IFIDRegisterRt;
   logic          IFIDUsesRt;
   logic          branch_taken;
   logic          dmem_req;
   logic          dmem_ready;
   logic          PCwrite, IFIDwrite, pipe_adv, controlmux, IFIDflush, IDEXflush;
   logic          mem_timeout;
   logic [CW-1:0] stall_cycles;
   logic [CW-1:0] flush_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .IDEXMemRead    (IDEXMemRead),
      .IDEXRegisterRt (IDEXRegisterRt),
      .IFIDRegisterRs (IFIDRegisterRs),
      .IFIDRegisterRt (IFIDRegisterRt),
      .IFIDUsesRt     (IFIDUsesRt),
      .branch_taken   (branch_taken),
      .dmem_req       (dmem_req),
      .dmem_ready     (dmem_ready),
      .PCwrite        (PCwrite),
      .IFIDwrite      (IFIDwrite),
      .pipe_adv       (pipe_adv),
      .controlmux     (controlmux),
      .IFIDflush      (IFIDflush),
      .IDEXflush      (IDEXflush),
      .mem_timeout    (mem_timeout),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   function automatic logic [5:0] ctl();
      return {PCwrite, IFIDwrite, pipe_adv, controlmux, IFIDflush, IDEXflush};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      IDEXMemRead    = 1'b0;
      IDEXRegisterRt = 5'd0;
      IFIDRegisterRs = 5'd0;
      IFIDRegisterRt = 5'd0;
      IFIDUsesRt     = 1'b0;
      branch_taken   = 1'b0;
      dmem_req       = 1'b0;
      dmem_ready     = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs);
      IDEXMemRead    = 1'b1;
      IDEXRegisterRt = rt;
      IFIDRegisterRs = rs;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #2;
      chk("rst_ctl", 16'(ctl()), 16'(C_HOLD));
      chk("rst_timeout", 16'(mem_timeout), 16'd0);
      chk("rst_stall", 16'(stall_cycles), 16'd0);
      chk("rst_flush", 16'(flush_count), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("idle_ctl", 16'(ctl()), 16'(C_NORM));

      // Load-use on rs
      set_lu(5'd5, 5'd5);
      #1 chk("lu_rs_ctl", 16'(ctl()), 16'(C_LU));
      cyc();
      idle();
      #1 chk("lu_rs_stall", 16'(stall_cycles), 16'd1);
      chk("lu_after_ctl", 16'(ctl()), 16'(C_NORM));

      // Rt = $zero never stalls
      set_lu(5'd0, 5'd0);
      #1 chk("lu_zero_ctl", 16'(ctl()), 16'(C_NORM));
      cyc();
      #1 chk("lu_zero_stall", 16'(stall_cycles), 16'd1);

      // Rt-only match gated by IFIDUsesRt
      set_lu(5'd7, 5'd3);
      IFIDRegisterRt = 5'd7;
      IFIDUsesRt     = 1'b0;
      #1 chk("rt_nouse_ctl", 16'(ctl()), 16'(C_NORM));
      IFIDUsesRt = 1'b1;
      #1 chk("rt_use_ctl", 16'(ctl()), 16'(C_LU));
      cyc();
      idle();
      #1 chk("rt_use_stall", 16'(stall_cycles), 16'd2);

      // Branch wins over simultaneous load-use
      set_lu(5'd5, 5'd5);
      branch_taken = 1'b1;
      #1 chk("br_lu_ctl", 16'(ctl()), 16'(C_BR));
      cyc();
      idle();
      #1 chk("br_flush_cnt", 16'(flush_count), 16'd1);
      chk("br_stall_cnt", 16'(stall_cycles), 16'd2);

      // Three-cycle memory freeze with branch held; branch applies on release
      dmem_req     = 1'b1;
      branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("frz%0d_ctl", i), 16'(ctl()), 16'(C_FRZ));
         cyc();
      end
      dmem_ready = 1'b1;
      #1 chk("frz_rel_ctl", 16'(ctl()), 16'(C_BR));
      cyc();
      idle();
      #1 chk("frz_stall", 16'(stall_cycles), 16'd5);
      chk("frz_flush", 16'(flush_count), 16'd2);
      chk("frz_run_ctl", 16'(ctl()), 16'(C_NORM));

      // Ready in the same cycle as request: no freeze, stays in RUN
      dmem_req   = 1'b1;
      dmem_ready = 1'b1;
      #1 chk("rdy_same_ctl", 16'(ctl()), 16'(C_NORM));
      cyc();
      dmem_req   = 1'b0;
      dmem_ready = 1'b0;
      #1 chk("rdy_next_ctl", 16'(ctl()), 16'(C_NORM));
      chk("rdy_stall", 16'(stall_cycles), 16'd5);

      // Timeout: HALT at the edge ending the 5th freeze cycle
      dmem_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("to%0d_ctl", i), 16'(ctl()), 16'(C_FRZ));
         cyc();
      end
      #1 chk("to4_ctl", 16'(ctl()), 16'(C_FRZ));
      chk("to4_timeout", 16'(mem_timeout), 16'd0);
      cyc();
      #1 chk("halt_timeout", 16'(mem_timeout), 16'd1);
      chk("halt_ctl", 16'(ctl()), 16'(C_HOLD));
      chk("halt_stall", 16'(stall_cycles), 16'd10);
      dmem_ready = 1'b1;
      #1 chk("halt_rdy_ctl", 16'(ctl()), 16'(C_HOLD));
      cyc();
      #1 chk("halt_sticky", 16'(mem_timeout), 16'd1);
      chk("halt_stall2", 16'(stall_cycles), 16'd10);

      // Async reset pulse mid-HALT
      rst_n = 1'b0;
      #1 chk("arst_timeout", 16'(mem_timeout), 16'd0);
      chk("arst_stall", 16'(stall_cycles), 16'd0);
      chk("arst_flush", 16'(flush_count), 16'd0);
      chk("arst_ctl", 16'(ctl()), 16'(C_HOLD));
      #1 rst_n = 1'b1;
      idle();
      @(negedge clk);
      #1 chk("arst_run_ctl", 16'(ctl()), 16'(C_NORM));

      // Saturation: 20 consecutive load-use cycles
      set_lu(5'd9, 5'd9);
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (i == 14) begin
            #1 chk("sat15_stall", 16'(stall_cycles), 16'd15);
         end
      end
      idle();
      #1 chk("sat20_stall", 16'(stall_cycles), 16'd15);
      chk("sat_flush", 16'(flush_count), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines load-use hazard detection, taken-branch flushing and a multi-cycle data-memory wait handshake into one prioritized set of stage-register write enables, bubble select and flush strobes. Sits beside the ID stage: it drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB enables. A small FSM tracks memory waits and a fatal timeout, and saturating counters report stall and flush cycles.

## Interface
- TIMEOUT, 64: max cycles in MEM_WAIT before fatal halt (≥2)
- CNT_W, 16: width of performance counters
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IDEXMemRead  in  1  instruction in EX is a load
- IDEXRegisterRt  in  5  load destination register
- IFIDRegisterRs  in  5  ID-stage source rs
- IFIDRegisterRt  in  5  ID-stage source rt
- IFIDUsesRt  in  1  ID-stage instruction reads rt (R-type, store, beq)
- branch_taken  in  1  branch resolved taken in EX this cycle
- dmem_req  in  1  MEM-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- PCwrite  out  1  1 = PC updates
- IFIDwrite  out  1  1 = IF/ID updates
- pipe_adv  out  1  1 = ID/EX, EX/MEM, MEM/WB update
- controlmux  out  1  1 = insert zero-control bubble into ID/EX
- IFIDflush  out  1  clear IF/ID to nop
- IDEXflush  out  1  clear ID/EX to nop
- mem_timeout  out  1  sticky fatal error
- stall_cycles  out  CNT_W  saturating count of freeze + load-use cycles
- flush_count  out  CNT_W  saturating count of branch flushes

## Operation
- States: RUN, MEM_WAIT, HALT.
- Load-use hit lu = IDEXMemRead & (IDEXRegisterRt != 0) & ((IDEXRegisterRt == IFIDRegisterRs) | (IFIDUsesRt & IDEXRegisterRt == IFIDRegisterRt)).
- Memory freeze mf = (state==MEM_WAIT | (state==RUN & dmem_req)) & !dmem_ready.
- Priority per cycle, highest first:
  - HALT: all enables 0, controlmux=1, flushes 0.
  - mf: PCwrite=IFIDwrite=pipe_adv=0, controlmux=0, flushes 0. branch_taken and lu are ignored because the frozen pipeline re-presents them.
  - branch_taken: PCwrite=1, IFIDwrite=1, pipe_adv=1, IFIDflush=1, IDEXflush=1, controlmux=0. A simultaneous lu is ignored because the dependent instruction is wrong-path.
  - lu: PCwrite=0, IFIDwrite=0, pipe_adv=1, controlmux=1 (one-bubble stall).
  - otherwise: all enables 1, controlmux=0, flushes 0.
- Transitions:
  - RUN→MEM_WAIT when dmem_req & !dmem_ready.
  - MEM_WAIT→RUN when dmem_ready; that cycle is a normal advance.
  - MEM_WAIT→HALT when the wait counter equals TIMEOUT-1 and !dmem_ready.
  - HALT exits only on reset.
- Wait counter: clog2(TIMEOUT) bits. Cleared in RUN, increments each MEM_WAIT cycle.
- stall_cycles increments on every mf or lu cycle. flush_count increments on every branch-priority cycle. Both saturate at all-ones and do not wrap.
- mem_timeout = (state==HALT).

## Timing
- Enables and flushes are combinational from the current state and inputs. Zero latency: they take effect at the same clock edge.
- State, wait counter and perf counters are registered on the rising edge.
- Reset (async, immediate) puts the FSM in RUN, clears all counters and drops mem_timeout to 0. While rst_n=0: PCwrite=IFIDwrite=pipe_adv=0, controlmux=1, IFIDflush=IDEXflush=0.
- Reset during MEM_WAIT or HALT returns to RUN. The first cycle after release evaluates normally.
- A dmem_req that is ready in the same cycle causes no freeze and no state change.
- A load-use stall lasts exactly one cycle per hazard occurrence. The controller adds no extra hold.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, HALT)
  - REG_ZERO = 5'd0
  - the default TIMEOUT/CNT_W values
- Sub-module load_use_detect is pure combinational, computes lu, and is reused by any forwarding-unit check.
- Top level contains the priority mux, FSM and counters.

## Test plan
- Load-use: IDEXMemRead=1, Rt=5, Rs=5 → one cycle with PCwrite=0, IFIDwrite=0, controlmux=1, stall_cycles 0→1. The same stimulus with Rt=0 → no stall.
- Rt-only match: Rt=7, IFIDRegisterRt=7, IFIDUsesRt=0 → no stall. Setting IFIDUsesRt=1 → stall.
- Branch with load-use in the same cycle: branch_taken=1 plus lu → IFIDflush=IDEXflush=1, PCwrite=1, controlmux=0, flush_count=1, stall_cycles unchanged.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high → 3 frozen cycles (all enables 0), back in RUN, stall_cycles=3. A branch_taken held during the freeze is applied on the release cycle.
- Timeout with TIMEOUT=4: dmem_ready held low → HALT entered at the edge ending the 5th freeze cycle, mem_timeout=1 and stays 1 even when ready rises. Async rst_n pulse mid-HALT → RUN, counters 0.
- Saturation with CNT_W=4: 20 load-use stalls → stall_cycles=15.
